// File: rtl/posit_pau_pkg.sv
// Shared types and constant helpers for the posit arithmetic unit result path.
package posit_pau_pkg;

  localparam int unsigned PAU_N_DEF    = 16;
  localparam int unsigned PAU_TAGW_DEF = 4;

  // Canonical special posit words, right-aligned in 64 bits: NaR is the sign bit alone.
  function automatic logic [63:0] posit_special(input int unsigned n, input logic nar);
    return nar ? (64'd1 << (n - 1)) : 64'd0;
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [PAU_N_DEF-1:0]    data;
    logic                    inf;
    logic                    zero;
    logic [PAU_TAGW_DEF-1:0] tag;
  } pau_res_t;

endpackage

// File: rtl/pau_sync_fifo.sv
// Generic show-ahead synchronous FIFO; head word is read straight from storage.
module pau_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push & ~do_pop) count_d = count_q + 1'b1;
    else if (do_pop & ~do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/posit_div_result_buf.sv
// Posit divider result stage: canonicalise, buffer, handshake out, sticky flags.
// Event counters are built only when POSIT_DIV_RES_STATS_EN is defined.
module posit_div_result_buf
  import posit_pau_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          div_done,
  input  logic [N-1:0]                  div_out,
  input  logic                          div_inf,
  input  logic                          div_zero,
  input  logic [TAGW-1:0]               div_tag,
  output logic                          in_ready,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [N-1:0]                  res_data,
  output logic                          res_inf,
  output logic                          res_zero,
  output logic [TAGW-1:0]               res_tag,
  output logic [occ_width(DEPTH)-1:0]   occupancy,
  input  logic                          flag_clr,
  output logic                          sticky_nar,
  output logic                          sticky_zero,
  output logic                          sticky_ovf,
  output logic [15:0]                   nar_cnt,
  output logic [15:0]                   drop_cnt
);

  typedef struct packed {
    logic [N-1:0]    data;
    logic            inf;
    logic            zero;
    logic [TAGW-1:0] tag;
  } entry_t;

  localparam int unsigned EW       = $bits(entry_t);
  localparam logic [63:0] NAR_FULL = posit_special(N, 1'b1);
  localparam logic [N-1:0] NAR_W   = NAR_FULL[N-1:0];
  localparam logic [63:0] ZRO_FULL = posit_special(N, 1'b0);
  localparam logic [N-1:0] ZERO_W  = ZRO_FULL[N-1:0];

  entry_t         wr_entry, rd_entry;
  logic [EW-1:0]  fifo_rdata;
  logic           full, empty, push, pop, drop;
  logic           sticky_nar_q, sticky_nar_d;
  logic           sticky_zero_q, sticky_zero_d;
  logic           sticky_ovf_q, sticky_ovf_d;

  assign in_ready  = ~full | res_ready;
  assign res_valid = ~empty;
  assign push      = div_done & in_ready;
  assign pop       = res_valid & res_ready;
  assign drop      = div_done & ~in_ready;

  // NaR takes priority when the divider raises both flags.
  always_comb begin
    wr_entry.tag  = div_tag;
    wr_entry.inf  = div_inf;
    wr_entry.zero = ~div_inf & div_zero;
    if (div_inf)       wr_entry.data = NAR_W;
    else if (div_zero) wr_entry.data = ZERO_W;
    else               wr_entry.data = div_out;
  end

  pau_sync_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(wr_entry),
    .rdata_o(fifo_rdata),
    .full_o (full),
    .empty_o(empty),
    .count_o(occupancy)
  );

  assign rd_entry = entry_t'(fifo_rdata);
  assign res_data = rd_entry.data;
  assign res_inf  = rd_entry.inf;
  assign res_zero = rd_entry.zero;
  assign res_tag  = rd_entry.tag;

  always_comb begin
    sticky_nar_d  = (sticky_nar_q  & ~flag_clr) | (push & wr_entry.inf);
    sticky_zero_d = (sticky_zero_q & ~flag_clr) | (push & wr_entry.zero);
    sticky_ovf_d  = (sticky_ovf_q  & ~flag_clr) | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_nar_q  <= 1'b0;
      sticky_zero_q <= 1'b0;
      sticky_ovf_q  <= 1'b0;
    end else begin
      sticky_nar_q  <= sticky_nar_d;
      sticky_zero_q <= sticky_zero_d;
      sticky_ovf_q  <= sticky_ovf_d;
    end
  end

  assign sticky_nar  = sticky_nar_q;
  assign sticky_zero = sticky_zero_q;
  assign sticky_ovf  = sticky_ovf_q;

`ifdef POSIT_DIV_RES_STATS_EN
  logic [15:0] nar_cnt_q, nar_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating counters; an increment in the clear cycle overrides the clear.
  always_comb begin
    nar_cnt_d  = nar_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push & wr_entry.inf) begin
      if (nar_cnt_q != '1) nar_cnt_d = nar_cnt_q + 16'd1;
    end else if (flag_clr) begin
      nar_cnt_d = '0;
    end
    if (drop) begin
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (flag_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nar_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      nar_cnt_q  <= nar_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign nar_cnt  = nar_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign nar_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_posit_div_result_buf.sv
// Bench for posit_div_result_buf: queue-based reference model plus directed checks.
module tb_posit_div_result_buf;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
`ifdef POSIT_DIV_RES_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            div_done = 1'b0;
  logic [N-1:0]    div_out = '0;
  logic            div_inf = 1'b0;
  logic            div_zero = 1'b0;
  logic [TAGW-1:0] div_tag = '0;
  logic            res_ready = 1'b0;
  logic            flag_clr = 1'b0;
  logic            in_ready, res_valid, res_inf, res_zero;
  logic [N-1:0]    res_data;
  logic [TAGW-1:0] res_tag;
  logic [2:0]      occupancy;
  logic            sticky_nar, sticky_zero, sticky_ovf;
  logic [15:0]     nar_cnt, drop_cnt;

  posit_div_result_buf #(.N(N), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .div_done(div_done), .div_out(div_out), .div_inf(div_inf),
    .div_zero(div_zero), .div_tag(div_tag), .in_ready(in_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_inf(res_inf), .res_zero(res_zero),
    .res_tag(res_tag), .occupancy(occupancy), .flag_clr(flag_clr), .sticky_nar(sticky_nar),
    .sticky_zero(sticky_zero), .sticky_ovf(sticky_ovf), .nar_cnt(nar_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        inf;
    logic        zero;
    logic [3:0]  tag;
  } ent_t;

  ent_t        mq[$];
  logic        m_snar = 1'b0, m_szero = 1'b0, m_sovf = 1'b0;
  logic [15:0] m_nar_cnt = '0, m_drop_cnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_snar = 0; m_szero = 0; m_sovf = 0;
      m_nar_cnt = 0; m_drop_cnt = 0;
    end else begin
      bit   full, rdy, pop, push, is_nar, is_zero;
      ent_t e;
      full    = (mq.size() == DEPTH);
      rdy     = !full || res_ready;
      pop     = (mq.size() != 0) && res_ready;
      push    = div_done && rdy;
      is_nar  = div_inf;
      is_zero = !div_inf && div_zero;
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.d    = is_nar ? 16'h8000 : (is_zero ? 16'h0000 : div_out);
        e.inf  = is_nar;
        e.zero = is_zero;
        e.tag  = div_tag;
        mq.push_back(e);
      end
      if (flag_clr) begin m_snar = 0; m_szero = 0; m_sovf = 0; end
      if (push && is_nar)  m_snar = 1;
      if (push && is_zero) m_szero = 1;
      if (div_done && !rdy) m_sovf = 1;
      if (STATS) begin
        if (push && is_nar) m_nar_cnt = (m_nar_cnt == 16'hFFFF) ? m_nar_cnt : m_nar_cnt + 1;
        else if (flag_clr) m_nar_cnt = 0;
        if (div_done && !rdy) m_drop_cnt = (m_drop_cnt == 16'hFFFF) ? m_drop_cnt : m_drop_cnt + 1;
        else if (flag_clr) m_drop_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
      chk("m_res_valid", 32'(res_valid), 32'(mq.size() != 0));
      chk("m_in_ready", 32'(in_ready), 32'((mq.size() != DEPTH) || res_ready));
      chk("m_sticky", {29'd0, sticky_nar, sticky_zero, sticky_ovf}, {29'd0, m_snar, m_szero, m_sovf});
      chk("m_nar_cnt", 32'(nar_cnt), 32'(m_nar_cnt));
      chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop_cnt));
      if (mq.size() != 0) begin
        chk("m_head", {10'd0, res_data, res_inf, res_zero, res_tag},
            {10'd0, mq[0].d, mq[0].inf, mq[0].zero, mq[0].tag});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] t, input logic inf, input logic z);
    div_done = 1'b1; div_out = d; div_tag = t; div_inf = inf; div_zero = z;
    step();
    div_done = 1'b0; div_inf = 1'b0; div_zero = 1'b0;
  endtask

  logic [15:0] order [4];

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_data_tag", {12'd0, res_data, res_tag}, 32'd0);
    chk("rst_sticky", {29'd0, sticky_nar, sticky_zero, sticky_ovf}, 32'd0);
    chk("rst_cnts", {nar_cnt, drop_cnt}, 32'd0);
    rst = 1'b0;
    step();

    // single result
    drive(16'h4000, 4'd3, 1'b0, 1'b0);
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_data", 32'(res_data), 32'h4000);
    chk("single_tag", 32'(res_tag), 32'd3);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("single_pop_occ", 32'(occupancy), 32'd0);

    // fill to full, then overflow
    for (int i = 0; i < 4; i++) drive(16'h1000 + 16'(i), 4'(i), 1'b0, 1'b0);
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(16'h5555, 4'd15, 1'b0, 1'b0);
    chk("drop_ovf", 32'(sticky_ovf), 32'd1);
    chk("drop_cnt", 32'(drop_cnt), STATS ? 32'd1 : 32'd0);
    chk("drop_occ", 32'(occupancy), 32'd4);
    chk("drop_head", 32'(res_data), 32'h1000);

    // full with simultaneous push and pop, order across wrap
    res_ready = 1'b1;
    div_done = 1'b1; div_out = 16'h2000; div_tag = 4'd5;
    #1;
    chk("fullpp_in_ready", 32'(in_ready), 32'd1);
    step();
    div_done = 1'b0;
    chk("fullpp_occ", 32'(occupancy), 32'd4);
    order[0] = 16'h1001; order[1] = 16'h1002; order[2] = 16'h1003; order[3] = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_order", 32'(res_data), 32'(order[i]));
      step();
    end
    chk("drain_occ", 32'(occupancy), 32'd0);

    // exceptions
    res_ready = 1'b0;
    drive(16'h1234, 4'd7, 1'b1, 1'b0);
    chk("nar_data", 32'(res_data), 32'h8000);
    chk("nar_flags", {30'd0, res_inf, res_zero}, 32'd2);
    chk("nar_sticky", 32'(sticky_nar), 32'd1);
    chk("nar_cnt1", 32'(nar_cnt), STATS ? 32'd1 : 32'd0);
    res_ready = 1'b1;
    drive(16'h7777, 4'd8, 1'b0, 1'b1);
    chk("zero_data", 32'(res_data), 32'h0000);
    chk("zero_flags", {30'd0, res_inf, res_zero}, 32'd1);
    chk("zero_sticky", 32'(sticky_zero), 32'd1);
    drive(16'h0F0F, 4'd9, 1'b1, 1'b1);
    chk("both_data", 32'(res_data), 32'h8000);
    chk("both_flags", {30'd0, res_inf, res_zero}, 32'd2);

    // clear vs set
    flag_clr = 1'b1;
    drive(16'h0001, 4'd10, 1'b1, 1'b0);
    chk("clrset_nar", 32'(sticky_nar), 32'd1);
    chk("clrset_zero_ovf", {30'd0, sticky_zero, sticky_ovf}, 32'd0);
    chk("clrset_nar_cnt", 32'(nar_cnt), STATS ? 32'd3 : 32'd0);
    step();
    flag_clr = 1'b0;
    chk("clr_sticky", {29'd0, sticky_nar, sticky_zero, sticky_ovf}, 32'd0);
    chk("clr_cnts", {nar_cnt, drop_cnt}, 32'd0);

    // async reset mid-stream
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(16'h0100 + 16'(i), 4'(i), 1'b0, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(res_valid), 32'd0);
    chk("async_occ", 32'(occupancy), 32'd0);
    div_done = 1'b1; div_out = 16'h7FFF;
    step();
    rst = 1'b0; div_done = 1'b0;
    step();
    chk("post_rst_occ", 32'(occupancy), 32'd0);

    // empty with push and ready together
    res_ready = 1'b1;
    drive(16'h3C00, 4'd9, 1'b0, 1'b0);
    chk("bypass_valid", 32'(res_valid), 32'd1);
    chk("bypass_data", {12'd0, res_data, res_tag}, {12'd0, 16'h3C00, 4'd9});
    step();
    chk("bypass_pop_occ", 32'(occupancy), 32'd0);
    res_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
